// File: rtl/icache_plru_victim_sel.sv
// icache_plru_victim_sel: tree-PLRU replacement state and victim picker.
// Victim is answered one cycle after alloc_req; invalid ways win over PLRU.
module icache_plru_victim_sel #(
    parameter int WAY_NUM = 8,
    parameter int SET_NUM = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       hit_vld,
    input  logic [$clog2(SET_NUM)-1:0] hit_set,
    input  logic [$clog2(WAY_NUM)-1:0] hit_way,
    input  logic                       alloc_req,
    input  logic [$clog2(SET_NUM)-1:0] alloc_set,
    input  logic [WAY_NUM-1:0]         alloc_way_vld,
    output logic                       alloc_vld,
    output logic [$clog2(WAY_NUM)-1:0] alloc_way_idx
);

    localparam int LW = $clog2(WAY_NUM);
    localparam int LS = $clog2(SET_NUM);
    localparam int TB = WAY_NUM - 1;

    typedef logic [TB-1:0] tree_t;
    typedef logic [LW-1:0] way_t;

    tree_t plru_q [SET_NUM];
    tree_t plru_d [SET_NUM];

    way_t  victim;
    way_t  plru_way;
    way_t  free_way;
    logic  all_vld;

    // Walk from the root following the bits; path bits form the way index.
    function automatic way_t tree_walk(input tree_t t);
        way_t node;
        way_t way;
        logic b;
        node = '0;
        way  = '0;
        for (int l = 0; l < LW; l++) begin
            b    = t[node];
            way  = LW'({way, b});
            node = LW'(32'(node) * 2 + 32'(b) + 1);
        end
        return way;
    endfunction

    // Make every node on the path to w point to the other half.
    function automatic tree_t tree_touch(input tree_t t, input way_t w);
        tree_t r;
        way_t  node;
        logic  dir;
        r    = t;
        node = '0;
        for (int l = 0; l < LW; l++) begin
            dir     = w[LW-1-l];
            r[node] = ~dir;
            node    = LW'(32'(node) * 2 + 32'(dir) + 1);
        end
        return r;
    endfunction

    // Lowest-index way whose valid bit is clear.
    function automatic way_t first_free(input logic [WAY_NUM-1:0] v);
        way_t idx;
        idx = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = LW'(i);
            end
        end
        return idx;
    endfunction

    // Victim from pre-update state of the requested set.
    always_comb begin
        all_vld  = &alloc_way_vld;
        plru_way = tree_walk(plru_q[alloc_set]);
        free_way = first_free(alloc_way_vld);
        victim   = all_vld ? plru_way : free_way;
    end

    // Next PLRU bits: hit touch first, then refill touch; flush clears all.
    always_comb begin
        tree_t t;
        for (int s = 0; s < SET_NUM; s++) begin
            t = plru_q[s];
            if (hit_vld && (hit_set == LS'(s))) begin
                t = tree_touch(t, hit_way);
            end
            if (alloc_req && (alloc_set == LS'(s))) begin
                t = tree_touch(t, victim);
            end
            plru_d[s] = flush ? '0 : t;
        end
    end

    // PLRU storage, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_NUM; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SET_NUM; s++) begin
                plru_q[s] <= plru_d[s];
            end
        end
    end

    // Registered response; index holds when no request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_vld     <= 1'b0;
            alloc_way_idx <= '0;
        end else begin
            alloc_vld <= alloc_req;
            if (alloc_req) begin
                alloc_way_idx <= victim;
            end
        end
    end

endmodule

// File: tb/tb_icache_plru_victim_sel.sv
// tb_icache_plru_victim_sel: directed and random checks of the PLRU picker
// against a per-set tree model built from the replacement rules.
module tb_icache_plru_victim_sel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       hit_vld;
    logic [5:0] hit_set;
    logic [2:0] hit_way;
    logic       alloc_req;
    logic [5:0] alloc_set;
    logic [7:0] alloc_way_vld;
    logic       alloc_vld;
    logic [2:0] alloc_way_idx;

    int checks = 0;
    int errors = 0;
    int tree [64][7];
    int exp_vld = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    icache_plru_victim_sel #(
        .WAY_NUM(8),
        .SET_NUM(64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .hit_vld      (hit_vld),
        .hit_set      (hit_set),
        .hit_way      (hit_way),
        .alloc_req    (alloc_req),
        .alloc_set    (alloc_set),
        .alloc_way_vld(alloc_way_vld),
        .alloc_vld    (alloc_vld),
        .alloc_way_idx(alloc_way_idx)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 64; s++)
            for (int n = 0; n < 7; n++)
                tree[s][n] = 0;
    endtask

    function automatic int m_victim(input int s, input logic [7:0] v);
        int node;
        int way;
        int b;
        if (v != 8'hFF) begin
            for (int i = 0; i < 8; i++)
                if (!v[i]) return i;
        end
        node = 0;
        way  = 0;
        for (int l = 0; l < 3; l++) begin
            b    = tree[s][node];
            way  = way * 2 + b;
            node = 2 * node + 1 + b;
        end
        return way;
    endfunction

    task automatic m_touch(input int s, input int w);
        int node;
        int d;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            d             = (w >> (2 - l)) & 1;
            tree[s][node] = 1 - d;
            node          = 2 * node + 1 + d;
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic hv,
                        input int hs, input int hw, input logic ar,
                        input int as, input logic [7:0] av,
                        input int want, input string tag);
        int vic;
        rst_n         = r;
        flush         = fl;
        hit_vld       = hv;
        hit_set       = hs[5:0];
        hit_way       = hw[2:0];
        alloc_req     = ar;
        alloc_set     = as[5:0];
        alloc_way_vld = av;
        vic = m_victim(as, av);
        if (!r) begin
            m_clear();
            exp_vld = 0;
            exp_idx = 0;
        end else begin
            if (fl) begin
                m_clear();
            end else begin
                if (hv) m_touch(hs, hw);
                if (ar) m_touch(as, vic);
            end
            exp_vld = ar ? 1 : 0;
            if (ar) exp_idx = vic;
        end
        @(posedge clk);
        #1;
        check({tag, ".vld"}, 32'(alloc_vld), exp_vld);
        check({tag, ".idx"}, 32'(alloc_way_idx), exp_idx);
        if (want >= 0) check({tag, ".want"}, 32'(alloc_way_idx), want);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs;
        int as;
        logic [7:0] av;
        m_clear();
        step(0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, "rst0");
        step(0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, "rst1");

        step(1, 0, 0, 0, 0, 1, 5, 8'hFF, 0, "t1");
        step(1, 0, 0, 0, 0, 0, 0, 8'hFF, 0, "t1hold");

        step(1, 0, 1, 5, 0, 0, 0, 8'hFF, -1, "t2hit0");
        step(1, 0, 0, 0, 0, 1, 5, 8'hFF, 4, "t2a");
        step(1, 0, 1, 5, 4, 0, 0, 8'hFF, -1, "t2hit4");
        step(1, 0, 0, 0, 0, 1, 5, 8'hFF, 2, "t2b");
        step(1, 0, 0, 0, 0, 0, 0, 8'hFF, 2, "t2hold");

        step(1, 0, 0, 0, 0, 1, 3, 8'hF7, 3, "t3a");
        step(1, 0, 0, 0, 0, 1, 3, 8'h00, 0, "t3b");

        step(1, 0, 1, 9, 0, 1, 9, 8'hFF, 0, "t4a");
        step(1, 0, 0, 0, 0, 1, 9, 8'hFF, 4, "t4b");

        step(1, 0, 1, 10, 0, 0, 0, 8'hFF, -1, "t5h10");
        step(1, 0, 1, 11, 2, 0, 0, 8'hFF, -1, "t5h11");
        step(1, 0, 1, 20, 7, 0, 0, 8'hFF, -1, "t5h20");
        step(1, 1, 1, 11, 5, 1, 10, 8'hFF, 4, "t5fl");
        step(1, 0, 0, 0, 0, 1, 10, 8'hFF, 0, "t5s10");
        step(1, 0, 0, 0, 0, 1, 11, 8'hFF, 0, "t5s11");
        step(1, 0, 0, 0, 0, 1, 20, 8'hFF, 0, "t5s20");

        step(0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, "t6rst");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 0, "t6a");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 4, "t6b");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 2, "t6c");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 6, "t6d");
        step(0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, "t6rst2");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 0, "t6e");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 4, "t6f");
        step(0, 0, 0, 0, 0, 1, 1, 8'hFF, 0, "t6drop");
        step(1, 0, 0, 0, 0, 1, 1, 8'hFF, 0, "t6g");

        for (int i = 0; i < 500; i++) begin
            hs = int'($urandom_range(0, 3));
            as = int'($urandom_range(0, 3));
            av = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 29) == 0),
                 1'($urandom),
                 hs,
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0),
                 as,
                 av,
                 -1,
                 "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
